pmem_req_ctrl: RTL and testbench

//  Clocked, handshaked successor to the combinational DPI memory port: accepts one load/store request

---
 rtl/pmem_pkg.sv | 41 ++++
 rtl/pmem_lfsr8.sv | 22 ++
 rtl/pmem_req_ctrl.sv | 141 ++++++++++++++
 tb/tb_pmem_req_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared state encoding, LFSR constants and pmem_read/pmem_write for pmem_req_ctrl.
// A sparse SV memory model backs the accessors.
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Right-shift Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Wide enough for LATENCY (255) plus the largest jitter (15)
  localparam int CNT_W = 9;

  logic [63:0] pmem_mem [logic [63:0]];
  int unsigned pmem_rd_cnt;
  int unsigned pmem_wr_cnt;

  function automatic logic [63:0] pmem_read(input logic [63:0] addr);
    pmem_rd_cnt++;
    if (pmem_mem.exists(addr)) return pmem_mem[addr];
    return 64'd0;
  endfunction

  function automatic void pmem_write(input logic [63:0] addr,
                                     input logic [63:0] data,
                                     input logic [7:0]  mask);
    logic [63:0] word;
    pmem_wr_cnt++;
    word = pmem_mem.exists(addr) ? pmem_mem[addr] : 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) word[8*i +: 8] = data[8*i +: 8];
    end
    pmem_mem[addr] = word;
  endfunction

endpackage

// File: rtl/pmem_lfsr8.sv
// 8-bit Galois LFSR that advances once per step pulse; supplies latency jitter.
// Only compiled when MEM_RAND_DELAY_EN is defined.
`ifdef MEM_RAND_DELAY_EN
module pmem_lfsr8
  import pmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= LFSR_SEED;
    end else if (step) begin
      out <= (out >> 1) ^ (out[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule
`endif

// File: rtl/pmem_req_ctrl.sv
// Single-outstanding load/store controller: accepts a request, waits LATENCY cycles, makes exactly one
// pmem_read/pmem_write call and holds the response until taken. MEM_RAND_DELAY_EN adds LFSR jitter.
module pmem_req_ctrl
  import pmem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LATENCY    = 1,
  parameter int MAX_JITTER = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("pmem_req_ctrl: DATA_W must be 32 or 64");
  end
  if (LATENCY < 0 || LATENCY > 255) begin : g_bad_latency
    $error("pmem_req_ctrl: LATENCY must be 0..255");
  end
  if (MAX_JITTER < 0 || MAX_JITTER > 15) begin : g_bad_jitter
    $error("pmem_req_ctrl: MAX_JITTER must be 0..15");
  end

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [BYTES-1:0]     wmask_q;

  logic                 misaligned;
  logic                 hi_lane;
  logic [63:0]          dpi_addr;
  logic [63:0]          dpi_wdata;
  logic [7:0]           dpi_wmask;
  logic [CNT_W-1:0]     wait_total;

  assign req_ready = (state == IDLE) && !rst;

  assign misaligned = |addr_q[OFF_W-1:0];

  // A 32-bit port sees one half of a 64-bit memory word, chosen by addr[2]
  assign hi_lane   = (DATA_W == 32) && addr_q[2];
  assign dpi_addr  = 64'(addr_q) & ~64'h7;
  assign dpi_wdata = {(64 / DATA_W){wdata_q}};
  assign dpi_wmask = 8'(wmask_q) << (hi_lane ? 3'd4 : 3'd0);

`ifdef MEM_RAND_DELAY_EN
  logic [7:0] lfsr_out;

  pmem_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (req_valid && req_ready),
    .out  (lfsr_out)
  );

  assign wait_total = CNT_W'(LATENCY) + CNT_W'(lfsr_out % 8'(MAX_JITTER + 1));
`else
  assign wait_total = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            if (wait_total == '0) begin
              state <= ACCESS;
            end else begin
              cnt   <= wait_total - CNT_W'(1);
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (cnt == '0) state <= ACCESS;
          else           cnt   <= cnt - CNT_W'(1);
        end

        // The single memory call happens on the edge that leaves ACCESS
        ACCESS: begin
          if (misaligned) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
          end else if (we_q) begin
            if (|wmask_q) pmem_write(dpi_addr, dpi_wdata, dpi_wmask);
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end else begin
            resp_rdata <= DATA_W'(pmem_read(dpi_addr) >> (hi_lane ? 32 : 0));
            resp_err   <= 1'b0;
          end
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_req_ctrl.sv
// Directed bench for pmem_req_ctrl: a 64-bit port with LATENCY=2 and a 32-bit port with LATENCY=0
// sharing one simulated memory.
module tb_pmem_req_ctrl;
  import pmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [7:0]  a_req_wmask;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [63:0] b_req_addr;
  logic [31:0] b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wmask;

  int total = 0;
  int bad   = 0;

  pmem_req_ctrl #(.ADDR_W(64), .DATA_W(64), .LATENCY(2), .MAX_JITTER(3)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  pmem_req_ctrl #(.ADDR_W(64), .DATA_W(32), .LATENCY(0), .MAX_JITTER(3)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request, releases it after the accept edge and counts edges until resp_valid.
  task automatic issue(input bit use_b, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] wm, output int lat);
    if (use_b) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
      b_req_wdata = wd[31:0]; b_req_wmask = wm[3:0];
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
      a_req_wdata = wd; a_req_wmask = wm;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    while (!(use_b ? b_resp_valid : a_resp_valid) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic txn(input string tag, input bit use_b, input logic we, input logic [63:0] addr,
                     input logic [63:0] wd, input logic [7:0] wm,
                     input int exp_lat, input logic [63:0] exp_rd, input logic exp_err);
    int lat;
    issue(use_b, we, addr, wd, wm, lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_rdata"}, use_b ? 64'(b_resp_rdata) : a_resp_rdata, exp_rd);
    check_eq({tag, "_err"}, 64'(use_b ? b_resp_err : a_resp_err), 64'(exp_err));
    take();
  endtask

  int unsigned rd0, wr0;
  int          lat;
  logic [63:0] held;
  logic        ok_v, ok_d, ok_r, seen;

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wmask = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_a_req_ready", 64'(a_req_ready), 64'd0);
    check_eq("rst_b_req_ready", 64'(b_req_ready), 64'd0);
    check_eq("rst_a_resp_valid", 64'(a_resp_valid), 64'd0);
    check_eq("rst_a_resp_rdata", a_resp_rdata, 64'd0);
    check_eq("rst_a_resp_err", 64'(a_resp_err), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req_ready", 64'(a_req_ready), 64'd1);
    @(posedge clk); #1;

    // Seed memory with a full store, then a plain load
    wr0 = pmem_wr_cnt;
    txn("st_init", 1'b0, 1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 3, 64'd0, 1'b0);
    check_eq("st_init_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd1);
    rd0 = pmem_rd_cnt;
    txn("ld_basic", 1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 3, 64'h1122_3344_5566_7788, 1'b0);
    check_eq("ld_basic_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd1);

    // Partial store keeps the untouched upper bytes
    txn("st_full10", 1'b0, 1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 3, 64'd0, 1'b0);
    txn("st_part", 1'b0, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 3, 64'd0, 1'b0);
    txn("ld_part", 1'b0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 3, 64'h0123_4567_CAFE_F00D, 1'b0);

    // Empty byte mask: normal response, memory untouched
    wr0 = pmem_wr_cnt;
    txn("st_nomask", 1'b0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 3, 64'd0, 1'b0);
    check_eq("st_nomask_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd0);
    txn("ld_nomask", 1'b0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 3, 64'h0123_4567_CAFE_F00D, 1'b0);

    // Misaligned load on the 64-bit port
    rd0 = pmem_rd_cnt;
    txn("ld_misal", 1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'h00, 3, 64'd0, 1'b1);
    check_eq("ld_misal_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd0);

    // Response backpressure while a second request waits
    a_resp_ready = 1'b0;
    issue(1'b0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, lat);
    check_eq("bp_lat", 64'(lat), 64'd3);
    held = a_resp_rdata;
    rd0  = pmem_rd_cnt;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 64'h8000_0000;
    ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      ok_v &= a_resp_valid;
      ok_d &= (a_resp_rdata == held);
      ok_r &= !a_req_ready;
    end
    check_eq("bp_valid_held", 64'(ok_v), 64'd1);
    check_eq("bp_rdata_held", 64'(ok_d), 64'd1);
    check_eq("bp_req_ready_low", 64'(ok_r), 64'd1);
    check_eq("bp_rdata", held, 64'h0123_4567_CAFE_F00D);
    check_eq("bp_no_new_calls", 64'(pmem_rd_cnt - rd0), 64'd0);
    a_req_valid = 1'b0;
    take();
    check_eq("bp_after_valid", 64'(a_resp_valid), 64'd0);
    check_eq("bp_after_req_ready", 64'(a_req_ready), 64'd1);

    // Reset while the request sits in WAIT drops it
    rd0 = pmem_rd_cnt;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 64'h8000_0000;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_req_ready", 64'(a_req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_mid_ready_after", 64'(a_req_ready), 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= a_resp_valid;
    end
    check_eq("rst_mid_no_resp", 64'(seen), 64'd0);
    check_eq("rst_mid_rd_calls", 64'(pmem_rd_cnt - rd0), 64'd0);

    // 32-bit port, zero latency, lane selection and half-word placement
    txn("st_lane", 1'b0, 1'b1, 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 3, 64'd0, 1'b0);
    txn("b_ld_hi", 1'b1, 1'b0, 64'h8000_0004, 64'd0, 8'h0, 1, 64'hAAAA_BBBB, 1'b0);
    txn("b_ld_lo", 1'b1, 1'b0, 64'h8000_0000, 64'd0, 8'h0, 1, 64'hCCCC_DDDD, 1'b0);
    wr0 = pmem_wr_cnt;
    txn("b_st_hi", 1'b1, 1'b1, 64'h8000_0004, 64'h5566_7788, 8'h3, 1, 64'd0, 1'b0);
    check_eq("b_st_hi_wr_calls", 64'(pmem_wr_cnt - wr0), 64'd1);
    txn("a_ld_merge", 1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 3, 64'hAAAA_7788_CCCC_DDDD, 1'b0);
    txn("b_ld_misal", 1'b1, 1'b0, 64'h8000_0002, 64'd0, 8'h0, 1, 64'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
